kamacore_stage_mem: RTL

//  Memory-access stage: consumes EX/MEM pipeline word, performs load/store via a req/gnt/rvalid dmem bus,
//  and registers the MEM/WB word (instr, rd_we, end_result) consumed by the writeback stage.

---
 rtl/kamacore_pkg.sv | 37 +++
 rtl/kamacore_lsu_align.sv | 59 +++++
 rtl/kamacore_stage_mem.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/kamacore_pkg.sv
// Shared types and constants for the kamacore memory stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kamacore_pkg;

    localparam int          CPU_WIDTH      = 32;
    localparam int          REG_ADDR_WIDTH = 5;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Halfword accesses need a[0]==0, word accesses need a[1:0]==0
    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            2'b01:   return lane[0];
            2'b10:   return |lane;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kamacore_lsu_align.sv
// Store byte-enable/lane replication and load byte/half extraction with extension.
// Latency: purely combinational.
// Backpressure: none; caller decides when results are used.
module kamacore_lsu_align
    import kamacore_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_result
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store: narrow data is replicated across all lanes so the slave only needs the enables
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_funct3)
            F3_SB: begin
                st_be    = 4'b0001 << st_lane;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_SH: begin
                st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Load: pick the addressed lane, then sign- or zero-extend by funct3
    always_comb begin
        case (ld_lane)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_LB:   ld_result = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_result = {24'd0, ld_byte};
            F3_LHU:  ld_result = {16'd0, ld_half};
            default: ld_result = ld_rdata;
        endcase
    end

endmodule

// File: rtl/kamacore_stage_mem.sv
// MEM pipeline stage: issues loads/stores on a req/gnt/rvalid bus and registers the MEM/WB word.
// Latency: non-mem ops 1 cycle; stores 1 cycle after gnt; loads 1 cycle after rvalid.
// Backpressure: ex_ready low whenever an access is in flight; WB side never stalls.
// Optional misaligned-access trap enabled by defining KAMACORE_MISALIGN_TRAP_EN.
module kamacore_stage_mem
    import kamacore_pkg::*;
#(
    parameter int CPU_WIDTH       = 32,
    parameter int DMEM_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    output logic                       ex_ready,
    input  logic [31:0]                ex_instr,
    input  logic [CPU_WIDTH-1:0]       ex_alu_result,
    input  logic [CPU_WIDTH-1:0]       ex_rs2_data,
    input  logic                       ex_rd_we,
    input  logic                       ex_mem_re,
    input  logic                       ex_mem_we,
    input  logic                       flush,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]                 dmem_be,
    output logic [31:0]                dmem_wdata,
    input  logic                       dmem_gnt,
    input  logic                       dmem_rvalid,
    input  logic [31:0]                dmem_rdata,
    output logic                       wb_valid,
    output logic [31:0]                wb_instr,
    output logic                       wb_rd_we,
    output logic [CPU_WIDTH-1:0]       wb_end_result,
    output logic                       mem_misalign
);

    mem_state_t           state_q, state_d;
    logic [31:0]          instr_q, instr_d;
    logic [CPU_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]           be_q, be_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 rd_we_q, rd_we_d;
    logic                 kill_q, kill_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [31:0]          wb_instr_q, wb_instr_d;
    logic                 wb_rd_we_q, wb_rd_we_d;
    logic [CPU_WIDTH-1:0] wb_result_q, wb_result_d;

    logic                 is_load, is_store, is_mem, ex_misalign;
    logic [3:0]           st_be;
    logic [31:0]          st_wdata, ld_result;

    // re&we together is illegal and resolves to a load
    assign is_load  = ex_mem_re;
    assign is_store = ex_mem_we & ~ex_mem_re;
    assign is_mem   = is_load | is_store;

    kamacore_lsu_align u_align (
        .st_funct3 (ex_instr[14:12]),
        .st_lane   (ex_alu_result[1:0]),
        .st_data   (ex_rs2_data),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_funct3 (instr_q[14:12]),
        .ld_lane   (addr_q[1:0]),
        .ld_rdata  (dmem_rdata),
        .ld_result (ld_result)
    );

`ifdef KAMACORE_MISALIGN_TRAP_EN
    logic misalign_q;
    assign ex_misalign = is_mem & addr_misaligned(ex_instr[14:12], ex_alu_result[1:0]);
    // One-cycle trap pulse, coincident with the no-write WB word for the trapped op
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= (state_q == IDLE) && ex_valid && !flush && ex_misalign;
    end
    assign mem_misalign = misalign_q;
`else
    assign ex_misalign  = 1'b0;
    assign mem_misalign = 1'b0;
`endif

    // Next-state, request capture and WB word selection
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rd_we_d     = rd_we_q;
        kill_d      = kill_q;
        wb_valid_d  = 1'b0;
        wb_rd_we_d  = 1'b0;
        wb_instr_d  = wb_instr_q;
        wb_result_d = wb_result_q;
        case (state_q)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (ex_misalign) begin
                        wb_valid_d  = 1'b1;
                        wb_instr_d  = ex_instr;
                        wb_result_d = ex_alu_result;
                    end else if (is_mem) begin
                        state_d = REQ;
                        instr_d = ex_instr;
                        addr_d  = ex_alu_result;
                        be_d    = st_be;
                        wdata_d = st_wdata;
                        we_d    = is_store;
                        rd_we_d = ex_rd_we;
                        kill_d  = 1'b0;
                    end else begin
                        wb_valid_d  = 1'b1;
                        wb_instr_d  = ex_instr;
                        wb_result_d = ex_alu_result;
                        wb_rd_we_d  = ex_rd_we;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    // A granted transaction always finishes on the bus; flush only suppresses WB
                    if (we_q) begin
                        state_d = IDLE;
                        if (!flush) begin
                            wb_valid_d  = 1'b1;
                            wb_instr_d  = instr_q;
                            wb_result_d = addr_q;
                        end
                    end else begin
                        state_d = RESP;
                        kill_d  = flush;
                    end
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                kill_d = kill_q | flush;
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    if (!(kill_q || flush)) begin
                        wb_valid_d  = 1'b1;
                        wb_instr_d  = instr_q;
                        wb_result_d = ld_result;
                        wb_rd_we_d  = rd_we_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and MEM/WB registers; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            instr_q     <= NOP_INSTR;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rd_we_q     <= 1'b0;
            kill_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_instr_q  <= NOP_INSTR;
            wb_rd_we_q  <= 1'b0;
            wb_result_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rd_we_q     <= rd_we_d;
            kill_q      <= kill_d;
            wb_valid_q  <= wb_valid_d;
            wb_instr_q  <= wb_instr_d;
            wb_rd_we_q  <= wb_rd_we_d;
            wb_result_q <= wb_result_d;
        end
    end

    assign ex_ready      = (state_q == IDLE);
    assign dmem_req      = (state_q == REQ);
    assign dmem_we       = we_q;
    assign dmem_addr     = {addr_q[DMEM_ADDR_WIDTH-1:2], 2'b00};
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_instr      = wb_instr_q;
    assign wb_rd_we      = wb_rd_we_q;
    assign wb_end_result = wb_result_q;

endmodule
